reg_share_arbiter: RTL

Round-robin write arbiter that shares a single WIDTH-bit holding register between NUM_REQ requesters. Each requester offers a data word with a valid/ready handshake. One winner per arbitration cycle is accepted and its word is written into the shared register, with a one-cycle update pulse and the winner's index. It sits in front of the shared configuration/data registers in the register/regfile library and replaces ad-hoc muxing of multiple writers onto one flop bank.

---
 rtl/reg_share_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/reg_share_arbiter.sv
//==============================================================================
// Module      : reg_share_arbiter
// Description : Round-robin write arbiter sharing one WIDTH-bit holding
//               register between NUM_REQ valid/ready requesters.
//               Optional macro REG_SHARE_ARB_WRITE_GAP_EN inserts one idle
//               GAP cycle after every transfer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module reg_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    localparam int IDW    = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_upd,
    output logic [IDW-1:0]           grant_id,
    output logic                     busy
);

    logic [IDW-1:0]   ptr_q;
    logic [WIDTH-1:0] dout_q;
    logic             dout_upd_q;
    logic [IDW-1:0]   grant_id_q;

    logic             found;
    logic [IDW-1:0]   win;
    logic             arb_en;
    logic             in_gap;
    logic             xfer;

    // Round-robin search starting just after the last grant; ptr itself is checked last
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int idx;
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

`ifdef REG_SHARE_ARB_WRITE_GAP_EN
    typedef enum logic [0:0] {
        ST_ARB = 1'b0,
        ST_GAP = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    assign arb_en = (state_q == ST_ARB);
    assign in_gap = (state_q == ST_GAP);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_ARB;
        else        state_q <= state_d;
    end

    // Every transfer is followed by exactly one GAP cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ARB:  if (xfer) state_d = ST_GAP;
            ST_GAP:  state_d = ST_ARB;
            default: state_d = ST_ARB;
        endcase
    end
`else
    assign arb_en = 1'b1;
    assign in_gap = 1'b0;
`endif

    // One-hot ready for the winner; forced low while reset is held
    always_comb begin
        req_ready = '0;
        if (rst_n && arb_en && found) req_ready[win] = 1'b1;
    end

    assign xfer = |req_ready;

    // Shared register, update pulse, grant index and priority pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q     <= '0;
            dout_upd_q <= 1'b0;
            grant_id_q <= '0;
            ptr_q      <= IDW'(NUM_REQ - 1);
        end else begin
            dout_upd_q <= xfer;
            if (xfer) begin
                dout_q     <= req_data[int'(win)*WIDTH +: WIDTH];
                grant_id_q <= win;
                ptr_q      <= win;
            end
        end
    end

    assign dout     = dout_q;
    assign dout_upd = dout_upd_q;
    assign grant_id = grant_id_q;
    assign busy     = (|req_valid) | in_gap;

endmodule

`default_nettype wire
